// File: rtl/logo_motion_ctrl.sv
// Frame-synchronous logo position scheduler: samples direction buttons every FRAME_DIV
// frame ticks and commits a clamped logo origin during vertical blanking. Optional macro: LOGO_AUTO_BOUNCE_EN.
module logo_motion_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int LOGO_W    = 120,
    parameter int LOGO_H    = 160,
    parameter int X_INIT    = 260,
    parameter int Y_INIT    = 160,
    parameter int FRAME_DIV = 2,
    parameter int STEP      = 1
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
`ifdef LOGO_AUTO_BOUNCE_EN
    input  logic       auto_en,
`endif
    output logic [9:0] logo_x,
    output logic [9:0] logo_y,
    output logic       pos_upd,
    output logic [3:0] at_edge
);

    localparam logic [9:0]        V_TICK   = 10'(V_ACTIVE);
    localparam logic [7:0]        DIV_LAST = 8'(FRAME_DIV - 1);
    localparam logic [9:0]        X_MAX    = 10'(H_ACTIVE - LOGO_W);
    localparam logic [9:0]        Y_MAX    = 10'(V_ACTIVE - LOGO_H);
    localparam logic signed [10:0] X_MAX_S = 11'(H_ACTIVE - LOGO_W);
    localparam logic signed [10:0] Y_MAX_S = 11'(V_ACTIVE - LOGO_H);
    localparam logic signed [10:0] STEP_S  = 11'(STEP);

    typedef enum logic [1:0] {IDLE, SAMPLE, CALC, COMMIT} state_t;

    state_t state, state_nxt;
    logic       tick;
    logic       start;
    logic [7:0] div_cnt;
    logic       btn_up, btn_down, btn_left, btn_right;

    logic signed [10:0] step_x, step_y;
    logic signed [10:0] cand_x, cand_y;
    logic [9:0]         next_x, next_y;

`ifdef LOGO_AUTO_BOUNCE_EN
    logic auto_q;
    logic dx_neg, dy_neg;
`endif

    // First cycle of vertical blanking
    assign tick  = (v_cnt == V_TICK) && (h_cnt == 10'd0);
    assign start = tick && (state == IDLE) && (div_cnt == DIV_LAST);

    always_ff @(posedge pclk) begin
        if (rst)
            div_cnt <= 8'd0;
        else if (tick && state == IDLE)
            div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
    end

    always_ff @(posedge pclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = CALC;
            CALC:    state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            btn_up    <= 1'b0;
            btn_down  <= 1'b0;
            btn_left  <= 1'b0;
            btn_right <= 1'b0;
`ifdef LOGO_AUTO_BOUNCE_EN
            auto_q    <= 1'b0;
`endif
        end else if (state == SAMPLE) begin
            btn_up    <= up;
            btn_down  <= down;
            btn_left  <= left;
            btn_right <= right;
`ifdef LOGO_AUTO_BOUNCE_EN
            auto_q    <= auto_en;
`endif
        end
    end

    // Opposing buttons cancel; the signed 11-bit sum never wraps before clamping
    always_comb begin
        step_x = 11'sd0;
        step_y = 11'sd0;
        if (btn_right && !btn_left) step_x = STEP_S;
        if (btn_left && !btn_right) step_x = -STEP_S;
        if (btn_down && !btn_up)    step_y = STEP_S;
        if (btn_up && !btn_down)    step_y = -STEP_S;
`ifdef LOGO_AUTO_BOUNCE_EN
        if (auto_q) begin
            step_x = dx_neg ? -STEP_S : STEP_S;
            step_y = dy_neg ? -STEP_S : STEP_S;
        end
`endif
        cand_x = $signed({1'b0, logo_x}) + step_x;
        cand_y = $signed({1'b0, logo_y}) + step_y;

        if (cand_x < 11'sd0)        next_x = 10'd0;
        else if (cand_x > X_MAX_S)  next_x = X_MAX;
        else                        next_x = cand_x[9:0];

        if (cand_y < 11'sd0)        next_y = 10'd0;
        else if (cand_y > Y_MAX_S)  next_y = Y_MAX;
        else                        next_y = cand_y[9:0];
    end

    // New origin is loaded on the CALC->COMMIT edge so it is visible with pos_upd
    always_ff @(posedge pclk) begin
        if (rst) begin
            logo_x  <= 10'(X_INIT);
            logo_y  <= 10'(Y_INIT);
            at_edge <= 4'b0000;
            pos_upd <= 1'b0;
        end else begin
            pos_upd <= (state == CALC);
            if (state == CALC) begin
                logo_x  <= next_x;
                logo_y  <= next_y;
                at_edge <= {next_y == 10'd0, next_y == Y_MAX, next_x == 10'd0, next_x == X_MAX};
            end
        end
    end

`ifdef LOGO_AUTO_BOUNCE_EN
    always_ff @(posedge pclk) begin
        if (rst) begin
            dx_neg <= 1'b0;
            dy_neg <= 1'b0;
        end else if (state == CALC && auto_q) begin
            if (cand_x >= X_MAX_S)     dx_neg <= 1'b1;
            else if (cand_x <= 11'sd0) dx_neg <= 1'b0;
            if (cand_y >= Y_MAX_S)     dy_neg <= 1'b1;
            else if (cand_y <= 11'sd0) dy_neg <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_logo_motion_ctrl.sv
// Randomized bench for logo_motion_ctrl with a cycle-level behavioural model and literal pins.
module tb_logo_motion_ctrl;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int LOGO_W    = 120;
    localparam int LOGO_H    = 160;
    localparam int X_INIT    = 260;
    localparam int Y_INIT    = 160;
    localparam int FRAME_DIV = 2;
    localparam int STEP      = 1;
    localparam int X_MAX     = H_ACTIVE - LOGO_W;
    localparam int Y_MAX     = V_ACTIVE - LOGO_H;

    logic       pclk = 1'b0;
    logic       rst;
    logic [9:0] h_cnt, v_cnt;
    logic       up, down, left, right;
    logic [9:0] logo_x, logo_y;
    logic       pos_upd;
    logic [3:0] at_edge;

    always #20 pclk = ~pclk;

    logo_motion_ctrl #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .LOGO_W(LOGO_W), .LOGO_H(LOGO_H),
        .X_INIT(X_INIT), .Y_INIT(Y_INIT), .FRAME_DIV(FRAME_DIV), .STEP(STEP)
    ) dut (
        .pclk(pclk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .up(up), .down(down), .left(left), .right(right),
        .logo_x(logo_x), .logo_y(logo_y), .pos_upd(pos_upd), .at_edge(at_edge)
    );

    int checks = 0;
    int errors = 0;

    // Model: expected outputs for the current cycle plus pending schedule
    int       cyc = 0;
    bit       chk_en = 0;
    bit       pend_rst = 0;
    int       m_x, m_y, cx, cy;
    bit [3:0] m_edge;
    bit       m_upd;
    int       div = 0;
    int       sample_cyc = -1, commit_cyc = -1, busy_end = -1;

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : (v > hi) ? hi : v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle; btn = {up,down,left,right}
    task automatic step(input bit r, input bit tk, input bit [3:0] btn);
        @(posedge pclk);
        #1;
        cyc++;
        m_upd = 0;
        if (pend_rst) begin
            m_x = X_INIT; m_y = Y_INIT; m_edge = 4'b0000;
            div = 0; sample_cyc = -1; commit_cyc = -1; busy_end = -1;
            chk_en = 1;
        end else if (cyc == commit_cyc) begin
            m_x = cx; m_y = cy;
            m_edge = {m_y == 0, m_y == Y_MAX, m_x == 0, m_x == X_MAX};
            m_upd = 1;
        end

        rst = r;
        {up, down, left, right} = btn;
        if (tk) begin
            v_cnt = 10'(V_ACTIVE);
            h_cnt = 10'd0;
        end else begin
            case ($urandom_range(0, 2))
                0: begin v_cnt = 10'(V_ACTIVE); h_cnt = 10'($urandom_range(1, 799)); end
                1: begin h_cnt = 10'd0; v_cnt = 10'($urandom_range(0, 524));
                         if (v_cnt == 10'(V_ACTIVE)) v_cnt = v_cnt + 10'd1; end
                default: begin h_cnt = 10'($urandom_range(1, 799)); v_cnt = 10'($urandom_range(0, 524)); end
            endcase
        end

        pend_rst = r;
        if (!r) begin
            if (cyc == sample_cyc) begin
                cx = clampi(m_x + STEP * (int'(btn[0]) - int'(btn[1])), X_MAX);
                cy = clampi(m_y + STEP * (int'(btn[2]) - int'(btn[3])), Y_MAX);
            end
            if (tk && cyc > busy_end) begin
                if (div == FRAME_DIV - 1) begin
                    div = 0;
                    sample_cyc = cyc + 1;
                    commit_cyc = cyc + 3;
                    busy_end   = cyc + 3;
                end else begin
                    div++;
                end
            end
        end
    endtask

    // Tick, then run to the cycle where a commit would show
    task automatic do_tick(input bit [3:0] btn);
        step(0, 1, btn);
        step(0, 0, btn);
        step(0, 0, btn);
        step(0, 0, btn);
    endtask

    always @(negedge pclk) begin
        if (chk_en) begin
            chk("logo_x", int'(logo_x), m_x);
            chk("logo_y", int'(logo_y), m_y);
            chk("at_edge", int'(at_edge), int'(m_edge));
            chk("pos_upd", int'(pos_upd), int'(m_upd));
        end
    end

    task automatic run_phase(input int ncyc, input int dir, input bit allow_rst);
        int gap;
        bit [3:0] btn;
        bit tk;
        bit r;
        gap = $urandom_range(2, 6);
        for (int i = 0; i < ncyc; i++) begin
            if (dir < 0 || $urandom_range(0, 7) == 0) btn = 4'($urandom_range(0, 15));
            else                                       btn = 4'(1 << dir);
            tk = 0;
            if (gap == 0) begin
                tk  = 1;
                gap = $urandom_range(2, 6);
            end else begin
                gap--;
            end
            r = allow_rst && ($urandom_range(0, 399) == 0);
            step(r, tk, btn);
        end
    endtask

    initial begin
        rst = 1'b1; up = 0; down = 0; left = 0; right = 0;
        h_cnt = 10'd1; v_cnt = 10'd0;

        step(1, 0, 4'b0000);
        step(1, 0, 4'b0000);
        step(0, 0, 4'b0000);
        @(negedge pclk);
        chk("reset logo_x", int'(logo_x), 260);
        chk("reset logo_y", int'(logo_y), 160);
        chk("reset at_edge", int'(at_edge), 0);
        chk("reset pos_upd", int'(pos_upd), 0);

        // No buttons: second tick commits an unchanged position
        do_tick(4'b0000);
        @(negedge pclk);
        chk("idle tick1 pos_upd", int'(pos_upd), 0);
        do_tick(4'b0000);
        @(negedge pclk);
        chk("idle tick2 pos_upd", int'(pos_upd), 1);
        chk("idle tick2 logo_x", int'(logo_x), 260);

        // Right over four ticks
        do_tick(4'b0001);
        @(negedge pclk);
        chk("right t1 pos_upd", int'(pos_upd), 0);
        do_tick(4'b0001);
        @(negedge pclk);
        chk("right t2 pos_upd", int'(pos_upd), 1);
        chk("right t2 logo_x", int'(logo_x), 261);
        do_tick(4'b0001);
        do_tick(4'b0001);
        @(negedge pclk);
        chk("right t4 logo_x", int'(logo_x), 262);

        // up+down cancel, right still moves
        do_tick(4'b1101);
        do_tick(4'b1101);
        @(negedge pclk);
        chk("updown logo_x", int'(logo_x), 263);
        chk("updown logo_y", int'(logo_y), 160);

        // Reset during CALC aborts the update
        do_tick(4'b0100);
        step(0, 1, 4'b0100);
        step(0, 0, 4'b0100);
        step(1, 0, 4'b0100);
        step(0, 0, 4'b0000);
        @(negedge pclk);
        chk("abort logo_x", int'(logo_x), 260);
        chk("abort logo_y", int'(logo_y), 160);
        chk("abort pos_upd", int'(pos_upd), 0);
        step(0, 0, 4'b0000);
        step(0, 0, 4'b0000);

        run_phase(1500, -1, 1);
        run_phase(5000, 1, 0);
        @(negedge pclk);
        chk("left edge x", int'(logo_x), 0);
        chk("left edge flag", int'(at_edge[1]), 1);
        run_phase(3000, 3, 0);
        @(negedge pclk);
        chk("top edge y", int'(logo_y), 0);
        chk("top edge flag", int'(at_edge[3]), 1);
        run_phase(8000, 0, 0);
        @(negedge pclk);
        chk("right edge x", int'(logo_x), X_MAX);
        chk("right edge flag", int'(at_edge[0]), 1);
        run_phase(5000, 2, 0);
        @(negedge pclk);
        chk("bottom edge y", int'(logo_y), Y_MAX);
        chk("bottom edge flag", int'(at_edge[2]), 1);
        run_phase(1500, -1, 1);

        for (int i = 0; i < 6; i++) step(0, 0, 4'b0000);
        @(negedge pclk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
